// File: rtl/rs_param_station.sv
// Reservation station: issue into the lowest free slot, CDB wakeup, single dispatch to the ALU.
// Define RS_AGE_SEL_EN to dispatch the oldest ready entry instead of the lowest-index one.
module rs_param_station #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rs_clear,
  output logic              rs_full,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [ROB_W-1:0]  issue_rob,
  input  logic              issue_qj_busy,
  input  logic [ROB_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic              issue_qk_busy,
  input  logic [ROB_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_rob,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              alu_ready,
  output logic              alu_valid,
  output logic [OP_W-1:0]   alu_op,
  output logic [ROB_W-1:0]  alu_rob,
  output logic [DATA_W-1:0] alu_vj,
  output logic [DATA_W-1:0] alu_vk
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] r_busy, r_qj_busy, r_qk_busy;
  logic [OP_W-1:0]    r_op  [RS_SIZE];
  logic [ROB_W-1:0]   r_rob [RS_SIZE];
  logic [ROB_W-1:0]   r_qj  [RS_SIZE];
  logic [ROB_W-1:0]   r_qk  [RS_SIZE];
  logic [DATA_W-1:0]  r_vj  [RS_SIZE];
  logic [DATA_W-1:0]  r_vk  [RS_SIZE];

  logic              r_alu_valid;
  logic [OP_W-1:0]   r_alu_op;
  logic [ROB_W-1:0]  r_alu_rob;
  logic [DATA_W-1:0] r_alu_vj, r_alu_vk;

  logic [RS_SIZE-1:0] w_ready;
  logic [IDX_W-1:0]   w_free_idx, w_disp_idx;
  logic               w_found, w_issue, w_disp, w_cap_j, w_cap_k;

  assign rs_full   = &r_busy;
  assign w_ready   = r_busy & ~r_qj_busy & ~r_qk_busy;
  assign w_issue   = issue_valid & ~rs_full;
  assign w_disp    = alu_ready & w_found;
  assign w_cap_j   = cdb_valid & issue_qj_busy & (issue_qj == cdb_rob);
  assign w_cap_k   = cdb_valid & issue_qk_busy & (issue_qk == cdb_rob);

  assign alu_valid = r_alu_valid;
  assign alu_op    = r_alu_op;
  assign alu_rob   = r_alu_rob;
  assign alu_vj    = r_alu_vj;
  assign alu_vk    = r_alu_vk;

  always_comb begin
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
  end

`ifdef RS_AGE_SEL_EN
  // r_age ranks busy entries: 0 = newest, count-1 = oldest; ranks stay dense.
  logic [IDX_W-1:0] r_age [RS_SIZE];
  logic [IDX_W-1:0] w_best_age;

  always_comb begin
    w_disp_idx = '0;
    w_best_age = '0;
    w_found    = 1'b0;
    for (int i = 0; i < RS_SIZE; i++)
      if (w_ready[i] && (!w_found || r_age[i] > w_best_age)) begin
        w_found    = 1'b1;
        w_disp_idx = IDX_W'(i);
        w_best_age = r_age[i];
      end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || rs_clear) begin
      for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_disp && w_disp_idx == IDX_W'(i))
          r_age[i] <= '0;
        else if (w_issue && w_free_idx == IDX_W'(i))
          r_age[i] <= '0;
        else if (r_busy[i])
          r_age[i] <= r_age[i] + IDX_W'(w_issue)
                      - IDX_W'(w_disp && (r_age[i] > r_age[w_disp_idx]));
      end
    end
  end
`else
  always_comb begin
    w_disp_idx = '0;
    w_found    = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (w_ready[i]) begin
        w_found    = 1'b1;
        w_disp_idx = IDX_W'(i);
      end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy      <= '0;
      r_qj_busy   <= '0;
      r_qk_busy   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]  <= '0;
        r_rob[i] <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
      end
      r_alu_valid <= 1'b0;
      r_alu_op    <= '0;
      r_alu_rob   <= '0;
      r_alu_vj    <= '0;
      r_alu_vk    <= '0;
    end else if (rs_clear) begin
      r_busy      <= '0;
      r_alu_valid <= 1'b0;
    end else if (rdy_in) begin
      r_alu_valid <= w_disp;
      // Payload comes from pre-edge state, so a same-cycle broadcast cannot alter it.
      if (w_disp) begin
        r_alu_op             <= r_op[w_disp_idx];
        r_alu_rob            <= r_rob[w_disp_idx];
        r_alu_vj             <= r_vj[w_disp_idx];
        r_alu_vk             <= r_vk[w_disp_idx];
        r_busy[w_disp_idx]   <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (cdb_valid && r_busy[i]) begin
          if (r_qj_busy[i] && r_qj[i] == cdb_rob) begin
            r_qj_busy[i] <= 1'b0;
            r_vj[i]      <= cdb_value;
          end
          if (r_qk_busy[i] && r_qk[i] == cdb_rob) begin
            r_qk_busy[i] <= 1'b0;
            r_vk[i]      <= cdb_value;
          end
        end
      end
      if (w_issue) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_op[w_free_idx]      <= issue_op;
        r_rob[w_free_idx]     <= issue_rob;
        r_qj[w_free_idx]      <= issue_qj;
        r_qk[w_free_idx]      <= issue_qk;
        r_qj_busy[w_free_idx] <= issue_qj_busy & ~w_cap_j;
        r_qk_busy[w_free_idx] <= issue_qk_busy & ~w_cap_k;
        r_vj[w_free_idx]      <= w_cap_j ? cdb_value : issue_vj;
        r_vk[w_free_idx]      <= w_cap_k ? cdb_value : issue_vk;
      end
    end
  end
endmodule

// File: tb/tb_rs_param_station.sv
// Self-checking bench for rs_param_station (RS_SIZE=4) against a slot/sequence-number model.
module tb_rs_param_station;
  localparam int N  = 4;
  localparam int RW = 4;
  localparam int OW = 6;
  localparam int DW = 32;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_in, rdy_in, rs_clear, rs_full;
  logic          issue_valid, issue_qj_busy, issue_qk_busy;
  logic [OW-1:0] issue_op;
  logic [RW-1:0] issue_rob, issue_qj, issue_qk;
  logic [DW-1:0] issue_vj, issue_vk;
  logic          cdb_valid;
  logic [RW-1:0] cdb_rob;
  logic [DW-1:0] cdb_value;
  logic          alu_ready, alu_valid;
  logic [OW-1:0] alu_op;
  logic [RW-1:0] alu_rob;
  logic [DW-1:0] alu_vj, alu_vk;

  rs_param_station #(.RS_SIZE(N), .ROB_W(RW), .OP_W(OW), .DATA_W(DW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rs_clear(rs_clear),
    .rs_full(rs_full), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_rob(issue_rob), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
    .issue_vj(issue_vj), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
    .issue_vk(issue_vk), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
    .cdb_value(cdb_value), .alu_ready(alu_ready), .alu_valid(alu_valid),
    .alu_op(alu_op), .alu_rob(alu_rob), .alu_vj(alu_vj), .alu_vk(alu_vk)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: slots hold instructions; age is a global issue sequence number.
  bit            m_busy [N];
  logic [OW-1:0] m_op   [N];
  logic [RW-1:0] m_rob  [N];
  bit            m_jp   [N];
  bit            m_kp   [N];
  logic [RW-1:0] m_jt   [N];
  logic [RW-1:0] m_kt   [N];
  logic [DW-1:0] m_vj   [N];
  logic [DW-1:0] m_vk   [N];
  int unsigned   m_seq  [N];
  int unsigned   m_next_seq = 0;
  bit            m_alu_valid;
  logic [OW-1:0] m_alu_op;
  logic [RW-1:0] m_alu_rob;
  logic [DW-1:0] m_alu_vj, m_alu_vk;

  function automatic bit model_full();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    int d, f;
    bit full;
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0; m_op[i] = '0; m_rob[i] = '0; m_jp[i] = 0; m_kp[i] = 0;
        m_jt[i] = '0; m_kt[i] = '0; m_vj[i] = '0; m_vk[i] = '0;
      end
      m_alu_valid = 0; m_alu_op = '0; m_alu_rob = '0; m_alu_vj = '0; m_alu_vk = '0;
      return;
    end
    if (rs_clear) begin
      for (int i = 0; i < N; i++) m_busy[i] = 0;
      m_alu_valid = 0;
      return;
    end
    if (!rdy_in) return;
    full = model_full();
    d = -1;
    for (int i = 0; i < N; i++)
      if (m_busy[i] && !m_jp[i] && !m_kp[i]) begin
`ifdef RS_AGE_SEL_EN
        if (d < 0 || m_seq[i] < m_seq[d]) d = i;
`else
        if (d < 0) d = i;
`endif
      end
    f = -1;
    for (int i = 0; i < N; i++) if (!m_busy[i] && f < 0) f = i;
    m_alu_valid = (d >= 0) && alu_ready;
    if (m_alu_valid) begin
      m_alu_op = m_op[d]; m_alu_rob = m_rob[d]; m_alu_vj = m_vj[d]; m_alu_vk = m_vk[d];
      m_busy[d] = 0;
    end
    for (int i = 0; i < N; i++)
      if (m_busy[i] && cdb_valid) begin
        if (m_jp[i] && m_jt[i] == cdb_rob) begin m_jp[i] = 0; m_vj[i] = cdb_value; end
        if (m_kp[i] && m_kt[i] == cdb_rob) begin m_kp[i] = 0; m_vk[i] = cdb_value; end
      end
    if (issue_valid && !full) begin
      m_busy[f] = 1; m_op[f] = issue_op; m_rob[f] = issue_rob;
      m_jt[f] = issue_qj; m_kt[f] = issue_qk;
      m_jp[f] = issue_qj_busy && !(cdb_valid && issue_qj == cdb_rob);
      m_kp[f] = issue_qk_busy && !(cdb_valid && issue_qk == cdb_rob);
      m_vj[f] = (issue_qj_busy && !m_jp[f]) ? cdb_value : issue_vj;
      m_vk[f] = (issue_qk_busy && !m_kp[f]) ? cdb_value : issue_vk;
      m_seq[f] = m_next_seq;
      m_next_seq++;
    end
  endtask

  task automatic idle();
    rst_in = 0; rs_clear = 0; issue_valid = 0; cdb_valid = 0;
    issue_qj_busy = 0; issue_qk_busy = 0;
  endtask

  task automatic set_issue(input logic [RW-1:0] rob, input bit jb, input logic [RW-1:0] jt,
                           input bit kb, input logic [RW-1:0] kt);
    issue_valid = 1; issue_rob = rob; issue_op = OW'($urandom);
    issue_qj_busy = jb; issue_qj = jt; issue_vj = $urandom;
    issue_qk_busy = kb; issue_qk = kt; issue_vk = $urandom;
  endtask

  // One clock: check rs_full before the edge, advance model, check alu outputs after.
  task automatic tick();
    logic [OW+RW+2*DW-1:0] got, exp;
    total++;
    if (rs_full !== model_full()) begin
      bad++; $display("FAIL rs_full: got %0b expected %0b", rs_full, model_full());
    end
    @(posedge clk_in);
    model_step();
    #1;
    total++;
    if (alu_valid !== m_alu_valid) begin
      bad++; $display("FAIL alu_valid: got %0b expected %0b", alu_valid, m_alu_valid);
    end
    got = {alu_op, alu_rob, alu_vj, alu_vk};
    exp = {m_alu_op, m_alu_rob, m_alu_vj, m_alu_vk};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL alu_payload: got %h expected %h", got, exp);
    end
  endtask

  task automatic do_reset();
    idle(); rst_in = 1; tick(); rst_in = 0;
  endtask

  task automatic test_reset();
    idle(); rst_in = 1; rdy_in = 1; alu_ready = 0;
    @(posedge clk_in); model_step();
    @(posedge clk_in); model_step(); #1;
    total++;
    if (rs_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b expected 0", rs_full); end
    total++;
    if (alu_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", alu_valid); end
    total++;
    if ({alu_op, alu_rob, alu_vj, alu_vk} !== '0) begin
      bad++; $display("FAIL reset_payload: got %h expected 0", {alu_op, alu_rob, alu_vj, alu_vk});
    end
    rst_in = 0;
    // Reset arriving in the cycle a ready entry would dispatch must cancel it.
    alu_ready = 1; set_issue(4'd3, 0, 0, 0, 0); tick(); idle();
    rst_in = 1; tick();
    total++;
    if (alu_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_dispatch: got %0b expected 0", alu_valid); end
    idle(); tick();
    total++;
    if (alu_valid !== 1'b0) begin bad++; $display("FAIL reset_no_late: got %0b expected 0", alu_valid); end
  endtask

  task automatic test_full();
    int got_robs[$];
    do_reset(); alu_ready = 0;
    for (int r = 1; r <= 4; r++) begin set_issue(RW'(r), 0, 0, 0, 0); tick(); end
    idle();
    total++;
    if (rs_full !== 1'b1) begin bad++; $display("FAIL full_after4: got %0b expected 1", rs_full); end
    set_issue(4'd5, 0, 0, 0, 0); tick(); idle();
    total++;
    if (rs_full !== 1'b1) begin bad++; $display("FAIL full_drop5: got %0b expected 1", rs_full); end
    alu_ready = 1;
    for (int c = 0; c < 8; c++) begin tick(); if (alu_valid) got_robs.push_back(int'(alu_rob)); end
    total++;
    if (got_robs.size() != 4 || got_robs[0] != 1 || got_robs[1] != 2 || got_robs[2] != 3 || got_robs[3] != 4) begin
      bad++; $display("FAIL full_drain: got %p expected '{1,2,3,4}", got_robs);
    end
  endtask

  task automatic test_wakeup();
    do_reset(); alu_ready = 1;
    set_issue(4'd5, 1, 4'd2, 0, 0); tick(); idle(); tick();
    total++;
    if (alu_valid !== 1'b0) begin bad++; $display("FAIL wake_pending: got %0b expected 0", alu_valid); end
    cdb_valid = 1; cdb_rob = 4'd2; cdb_value = 32'h1234; tick(); idle();
    total++;
    if (alu_valid !== 1'b0) begin bad++; $display("FAIL wake_early: got %0b expected 0", alu_valid); end
    tick();
    total++;
    if (alu_valid !== 1'b1 || alu_vj !== 32'h1234 || alu_rob !== 4'd5) begin
      bad++; $display("FAIL wake_dispatch: got v=%0b vj=%h rob=%0d expected v=1 vj=1234 rob=5",
                      alu_valid, alu_vj, alu_rob);
    end
  endtask

  task automatic test_issue_capture();
    bit seen = 0;
    logic [DW-1:0] vk = '0;
    logic [RW-1:0] rob = '0;
    do_reset(); alu_ready = 1;
    set_issue(4'd6, 0, 0, 1, 4'd3);
    cdb_valid = 1; cdb_rob = 4'd3; cdb_value = 32'hAA;
    tick(); idle();
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (alu_valid) begin seen = 1; vk = alu_vk; rob = alu_rob; end
    end
    total++;
    if (!seen || vk !== 32'hAA || rob !== 4'd6) begin
      bad++; $display("FAIL issue_capture: got seen=%0b vk=%h rob=%0d expected seen=1 vk=aa rob=6", seen, vk, rob);
    end
  endtask

  task automatic test_age_select();
    int got_robs[$];
    int exp_robs[4];
`ifdef RS_AGE_SEL_EN
    exp_robs = '{2, 3, 4, 9};
`else
    exp_robs = '{9, 2, 3, 4};
`endif
    do_reset(); alu_ready = 0;
    set_issue(4'd1, 0, 0, 0, 0); tick();
    for (int r = 2; r <= 4; r++) begin set_issue(RW'(r), 1, 4'd7, 0, 0); tick(); end
    idle(); alu_ready = 1; tick();
    total++;
    if (alu_valid !== 1'b1 || alu_rob !== 4'd1) begin
      bad++; $display("FAIL age_first: got v=%0b rob=%0d expected v=1 rob=1", alu_valid, alu_rob);
    end
    alu_ready = 0; set_issue(4'd9, 1, 4'd7, 0, 0); tick(); idle();
    cdb_valid = 1; cdb_rob = 4'd7; cdb_value = $urandom; tick(); idle();
    alu_ready = 1;
    for (int c = 0; c < 8; c++) begin tick(); if (alu_valid) got_robs.push_back(int'(alu_rob)); end
    total++;
    if (got_robs.size() != 4 || got_robs[0] != exp_robs[0] || got_robs[1] != exp_robs[1] ||
        got_robs[2] != exp_robs[2] || got_robs[3] != exp_robs[3]) begin
      bad++; $display("FAIL age_order: got %p expected %p", got_robs, exp_robs);
    end
  endtask

  task automatic test_clear();
    int pulses = 0;
    do_reset(); alu_ready = 0;
    for (int r = 1; r <= 4; r++) begin set_issue(RW'(r), 0, 0, 0, 0); tick(); end
    idle();
    rdy_in = 0; rs_clear = 1; tick(); rs_clear = 0;
    total++;
    if (rs_full !== 1'b0 || alu_valid !== 1'b0) begin
      bad++; $display("FAIL clear_now: got full=%0b v=%0b expected 0 0", rs_full, alu_valid);
    end
    rdy_in = 1; alu_ready = 1;
    for (int c = 0; c < 5; c++) begin tick(); if (alu_valid) pulses++; end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL clear_later: got %0d dispatches expected 0", pulses); end
  endtask

  task automatic test_pause();
    int pulses = 0;
    do_reset(); alu_ready = 0;
    set_issue(4'd7, 0, 0, 0, 0); tick(); idle();
    alu_ready = 1; rdy_in = 0;
    for (int c = 0; c < 3; c++) begin tick(); if (alu_valid) pulses++; end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL pause_hold: got %0d pulses expected 0", pulses); end
    rdy_in = 1;
    for (int c = 0; c < 4; c++) begin tick(); if (alu_valid) pulses++; end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL pause_resume: got %0d pulses expected 1", pulses); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_in    = ($urandom_range(0, 99) == 0);
      rs_clear  = ($urandom_range(0, 39) == 0);
      rdy_in    = ($urandom_range(0, 99) < 85);
      alu_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 60)
        set_issue(RW'($urandom), $urandom_range(0, 1), RW'($urandom_range(0, 3)),
                  $urandom_range(0, 1), RW'($urandom_range(0, 3)));
      else issue_valid = 0;
      cdb_valid = ($urandom_range(0, 99) < 50);
      cdb_rob   = RW'($urandom_range(0, 3));
      cdb_value = $urandom;
      tick();
    end
    idle(); rdy_in = 1;
  endtask

  initial begin
    idle();
    rdy_in = 1; alu_ready = 0; issue_op = '0; issue_rob = '0; issue_qj = '0; issue_qk = '0;
    issue_vj = '0; issue_vk = '0; cdb_rob = '0; cdb_value = '0;
    test_reset();
    test_full();
    test_wakeup();
    test_issue_capture();
    test_age_select();
    test_clear();
    test_pause();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
